// File: rtl/spi_burst_reader_if.sv
// rtl/spi_burst_reader_if.sv - pin and sample bus bundle for spi_burst_reader
//
// Signals:
//   continuous   : 1 = back-to-back bursts, 0 = one burst per start request
//   start        : burst request pulse
//   MISO         : serial data from the device
//   SCLK         : SPI clock, mode 0 (idle low)
//   MOSI         : serial data to the device
//   n_CS         : active-low chip select
//   samples      : NUM_CH packed samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   sample_valid : one-cycle pulse when samples updates
//   busy         : high whenever the sequencer is not idle
// Modports: master = the SPI master block, slave = the device/host side.
interface spi_burst_reader_if #(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 12
);
    logic                         continuous;
    logic                         start;
    logic                         MISO;
    logic                         SCLK;
    logic                         MOSI;
    logic                         n_CS;
    logic [NUM_CH*SAMPLE_W-1:0]   samples;
    logic                         sample_valid;
    logic                         busy;

    modport master (
        input  continuous, start, MISO,
        output SCLK, MOSI, n_CS, samples, sample_valid, busy
    );

    modport slave (
        output continuous, start, MISO,
        input  SCLK, MOSI, n_CS, samples, sample_valid, busy
    );
endinterface

// File: rtl/spi_burst_reader.sv
// rtl/spi_burst_reader.sv - SPI master: one config write, then NUM_CH-sample burst reads
//
// Ports:
//   clk_SPI : sole block clock, rising edge
//   reset   : synchronous, active-low
//   bus     : spi_burst_reader_if.master (controls, SPI pins, sample outputs)
// After reset one INIT frame (0x0A, INIT_ADDR, INIT_DATA) is sent, then READ
// frames (0x0B, BASE_ADDR, 2*NUM_CH data bytes) run continuously or per start
// request. Each READ publishes all channels at once with a one-cycle strobe.
module spi_burst_reader #(
    parameter int          CLK_DIV   = 4,
    parameter int          NUM_CH    = 3,
    parameter int          SAMPLE_W  = 12,
    parameter logic [7:0]  BASE_ADDR = 8'h0E,
    parameter logic [7:0]  INIT_ADDR = 8'h2D,
    parameter logic [7:0]  INIT_DATA = 8'h02,
    parameter int          GAP_CYC   = 4
) (
    input  logic                 clk_SPI,
    input  logic                 reset,
    spi_burst_reader_if.master   bus
);
    localparam int              SW          = NUM_CH * SAMPLE_W;
    localparam int              CW          = 16;
    localparam logic [CW-1:0]   C_HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   C_BIT_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]   C_GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [4:0]      C_INIT_LAST = 5'd2;
    localparam logic [4:0]      C_READ_LAST = 5'(2 * NUM_CH + 1);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHIFT, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;        // phase within bit, hold or gap cycle count
    logic [2:0]      r_bit;        // bit within current byte, 0 = MSB
    logic [4:0]      r_byte;       // byte index within frame
    logic            r_is_read;
    logic            r_init_done;
    logic            r_pending;
    logic [6:0]      r_rx;
    logic [SW-1:0]   r_stage;
    logic [SW-1:0]   r_samples;
    logic            r_valid;

    logic            w_want_read;
    logic [4:0]      w_last_byte;
    logic            w_bit_end;
    logic            w_frame_end;
    logic            w_sample;
    logic            w_launch;
    logic            w_hold_done;
    logic [7:0]      w_rx_byte;
    logic [3:0]      w_ch;
    logic [7:0]      w_tx_byte;

    assign w_want_read = bus.continuous | r_pending;
    assign w_last_byte = r_is_read ? C_READ_LAST : C_INIT_LAST;
    assign w_bit_end   = (r_state == S_SHIFT) && (r_cnt == C_BIT_LAST);
    assign w_frame_end = w_bit_end && (r_bit == 3'd7) && (r_byte == w_last_byte);
    // MISO is taken on the edge that raises SCLK, i.e. the last low-phase cycle
    assign w_sample    = (r_state == S_SHIFT) && (r_cnt == C_HALF_LAST);
    assign w_launch    = (w_next == S_SHIFT) && (r_state != S_SHIFT);
    assign w_hold_done = (r_state == S_HOLD) && (w_next == S_GAP);
    assign w_rx_byte   = {r_rx, bus.MISO};
    // data byte j = r_byte-2 belongs to channel j/2
    assign w_ch        = 4'((r_byte - 5'd2) >> 1);

    always_ff @(posedge clk_SPI) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // leaving reset goes through a full gap before INIT
                if (!r_init_done) begin
                    w_next = S_GAP;
                end else if (w_want_read) begin
                    w_next = S_SHIFT;
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    if (!r_init_done || w_want_read) begin
                        w_next = S_SHIFT;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_SHIFT: begin
                if (w_frame_end) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == C_HALF_LAST) begin
                    w_next = S_GAP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_byte)
            5'd0:    w_tx_byte = r_is_read ? 8'h0B : 8'h0A;
            5'd1:    w_tx_byte = r_is_read ? BASE_ADDR : INIT_ADDR;
            5'd2:    w_tx_byte = r_is_read ? 8'h00 : INIT_DATA;
            default: w_tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_SPI) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_is_read   <= 1'b0;
            r_init_done <= 1'b0;
            r_pending   <= 1'b0;
            r_rx        <= '0;
            r_stage     <= '0;
            r_samples   <= '0;
            r_valid     <= 1'b0;
        end else begin
            if ((r_state != w_next) || w_bit_end) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_launch) begin
                r_bit     <= '0;
                r_byte    <= '0;
                r_is_read <= r_init_done;
            end else if (w_bit_end) begin
                r_bit <= r_bit + 3'd1;
                if (r_bit == 3'd7) begin
                    r_byte <= r_byte + 5'd1;
                end
            end

            if (w_sample) begin
                r_rx <= w_rx_byte[6:0];
                if (r_is_read && (r_bit == 3'd7) && (r_byte >= 5'd2)) begin
                    if (!r_byte[0]) begin
                        r_stage[w_ch*SAMPLE_W +: 8] <= w_rx_byte;
                    end else begin
                        r_stage[w_ch*SAMPLE_W + 8 +: SAMPLE_W-8] <= w_rx_byte[SAMPLE_W-9:0];
                    end
                end
            end

            // a start coinciding with a launch is a fresh request and survives
            if (bus.start) begin
                r_pending <= 1'b1;
            end else if (w_launch && r_init_done) begin
                r_pending <= 1'b0;
            end

            if (w_hold_done && !r_is_read) begin
                r_init_done <= 1'b1;
            end

            if (w_hold_done && r_is_read) begin
                r_samples <= r_stage;
                r_valid   <= 1'b1;
            end else begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign bus.n_CS         = !((r_state == S_SHIFT) || (r_state == S_HOLD));
    assign bus.SCLK         = (r_state == S_SHIFT) && (r_cnt > C_HALF_LAST);
    assign bus.MOSI         = (r_state == S_SHIFT) && w_tx_byte[~r_bit];
    assign bus.samples      = r_samples;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_burst_reader.sv
// tb/tb_spi_burst_reader.sv - scoreboard bench for spi_burst_reader
module tb_spi_burst_reader;
    logic clk;
    logic rst_a;
    logic rst_b;

    spi_burst_reader_if #(.NUM_CH(3), .SAMPLE_W(12)) ifa ();
    spi_burst_reader_if #(.NUM_CH(1), .SAMPLE_W(16)) ifb ();

    spi_burst_reader #(.CLK_DIV(2)) u_a (
        .clk_SPI (clk),
        .reset   (rst_a),
        .bus     (ifa)
    );

    spi_burst_reader #(.CLK_DIV(1), .NUM_CH(1), .SAMPLE_W(16)) u_b (
        .clk_SPI (clk),
        .reset   (rst_b),
        .bus     (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          len;
        logic [23:0] mosi;
        logic        rd;
        int          gap;
    } frame_t;

    frame_t      exp_fq[$];
    logic [35:0] exp_sq[$];

    task automatic push_frame(input int len, input logic [23:0] m, input logic rd, input int gap);
        frame_t f;
        f.len  = len;
        f.mosi = m;
        f.rd   = rd;
        f.gap  = gap;
        exp_fq.push_back(f);
    endtask

    // ---------------- device models (mode 0: shift out on SCLK fall) ----------
    logic [7:0] resp_a [6];
    logic [7:0] resp_b [2];
    int   dev_cnt_a = 0;
    int   dev_cnt_b = 0;
    logic dev_psclk_a = 1'b0;
    logic dev_psclk_b = 1'b0;

    always @(negedge clk) begin
        int b;
        if (ifa.n_CS) dev_cnt_a = 0;
        else if (dev_psclk_a && !ifa.SCLK) dev_cnt_a++;
        dev_psclk_a = ifa.SCLK;
        b = dev_cnt_a / 8;
        if (!ifa.n_CS && b >= 2 && b < 8) ifa.MISO = resp_a[b-2][7 - (dev_cnt_a % 8)];
        else ifa.MISO = 1'b0;
    end

    always @(negedge clk) begin
        int b;
        if (ifb.n_CS) dev_cnt_b = 0;
        else if (dev_psclk_b && !ifb.SCLK) dev_cnt_b++;
        dev_psclk_b = ifb.SCLK;
        b = dev_cnt_b / 8;
        if (!ifb.n_CS && b >= 2 && b < 4) ifb.MISO = resp_b[b-2][7 - (dev_cnt_b % 8)];
        else ifb.MISO = 1'b0;
    end

    // ---------------- frame / sample monitor for DUT A -------------------------
    int          len_a = 0;
    int          gap_a = -1;
    int          gap_meas_a = -1;
    int          mbits_a = 0;
    logic [23:0] msh_a = '0;
    logic        pcs_a = 1'b1;
    logic        psclk_a = 1'b0;
    logic        pvalid_a = 1'b0;
    frame_t      mon_f;

    always @(negedge clk) begin
        if (!rst_a) begin
            len_a    = 0;
            gap_a    = -1;
            mbits_a  = 0;
            pcs_a    = 1'b1;
            psclk_a  = 1'b0;
            pvalid_a = 1'b0;
        end else begin
            if (pvalid_a) chk("valid_one_cycle", ifa.sample_valid, 0);
            if (ifa.sample_valid) begin
                if (exp_sq.size() == 0) chk("samples_unexpected", exp_sq.size(), 1);
                else chk("samples", ifa.samples, exp_sq.pop_front());
            end
            if (!ifa.n_CS) begin
                if (pcs_a) begin
                    gap_meas_a = gap_a;
                    len_a      = 0;
                    mbits_a    = 0;
                    msh_a      = '0;
                end
                len_a++;
                if (ifa.SCLK && !psclk_a && mbits_a < 24) begin
                    msh_a = {msh_a[22:0], ifa.MOSI};
                    mbits_a++;
                end
            end else begin
                if (!pcs_a) begin
                    if (exp_fq.size() == 0) begin
                        chk("frame_unexpected", exp_fq.size(), 1);
                    end else begin
                        mon_f = exp_fq.pop_front();
                        chk("frame_len", len_a, mon_f.len);
                        chk("frame_mosi", msh_a, mon_f.mosi);
                        chk("valid_at_cs_rise", ifa.sample_valid, mon_f.rd);
                        if (mon_f.gap >= 0) chk("gap_len", gap_meas_a, mon_f.gap);
                    end
                    gap_a = 0;
                end
                if (gap_a >= 0) gap_a++;
            end
            pcs_a    = ifa.n_CS;
            psclk_a  = ifa.SCLK;
            pvalid_a = ifa.sample_valid;
        end
    end

    // ---------------- helpers --------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fq(input int n, input int budget, input string tag);
        int k = 0;
        while (exp_fq.size() > n && k < budget) begin tick(1); k++; end
        chk(tag, k >= budget, 0);
    endtask

    task automatic wait_cs_low_a(input int budget, input string tag);
        int k = 0;
        while (ifa.n_CS && k < budget) begin tick(1); k++; end
        chk(tag, k >= budget, 0);
    endtask

    task automatic wait_idle_a(input int budget, input string tag);
        int k = 0;
        while ((exp_fq.size() != 0 || exp_sq.size() != 0 || ifa.busy) && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, k >= budget, 0);
    endtask

    task automatic pulse_start_a();
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
    endtask

    task automatic load_resp_a(input logic [47:0] v);
        for (int i = 0; i < 6; i++) resp_a[i] = v[47 - 8*i -: 8];
    endtask

    localparam logic [35:0] SMP1 = 36'h800_FFF_134;
    localparam logic [35:0] SMP2 = 36'h37F_C12_5AB;

    // ---------------- main sequence --------------------------------------------
    initial begin
        int k;
        int r1;
        int r2;
        logic ps;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.continuous = 1'b0;
        ifa.start      = 1'b0;
        ifb.continuous = 1'b0;
        ifb.start      = 1'b0;
        load_resp_a(48'h34_01_FF_0F_00_08);
        resp_b[0] = 8'hCD;
        resp_b[1] = 8'hAB;

        tick(4);
        chk("rst_ncs", ifa.n_CS, 1);
        chk("rst_sclk", ifa.SCLK, 0);
        chk("rst_mosi", ifa.MOSI, 0);
        chk("rst_samples", ifa.samples, 0);
        chk("rst_valid", ifa.sample_valid, 0);
        chk("rst_busy", ifa.busy, 0);

        // INIT after reset, then idle with continuous=0
        push_frame(98, 24'h0A2D02, 1'b0, -1);
        rst_a = 1'b1;
        k = 0;
        do begin tick(1); k++; end while (ifa.n_CS && k < 50);
        chk("init_latency", k, 5);
        wait_idle_a(400, "init_timeout");
        tick(30);
        chk("idle_ncs", ifa.n_CS, 1);
        chk("idle_busy", ifa.busy, 0);

        // single request, then three starts during it collapse to one READ
        push_frame(258, 24'h0B0E00, 1'b1, -1);
        exp_sq.push_back(SMP1);
        push_frame(258, 24'h0B0E00, 1'b1, 4);
        exp_sq.push_back(SMP1);
        pulse_start_a();
        chk("start_pre_ncs", ifa.n_CS, 1);
        tick(1);
        chk("start_latency", ifa.n_CS, 0);
        tick(20);
        for (int i = 0; i < 3; i++) begin
            pulse_start_a();
            tick(30);
        end
        wait_idle_a(1500, "pending_timeout");
        tick(20);
        chk("no_extra_read", ifa.busy, 0);

        // start during INIT: READ follows the gap directly
        rst_a = 1'b0;
        tick(3);
        push_frame(98, 24'h0A2D02, 1'b0, -1);
        push_frame(258, 24'h0B0E00, 1'b1, 4);
        exp_sq.push_back(SMP1);
        rst_a = 1'b1;
        tick(20);
        pulse_start_a();
        wait_idle_a(1000, "init_read_timeout");

        // continuous bursts with masked high bytes
        load_resp_a(48'hAB_F5_12_0C_7F_93);
        push_frame(258, 24'h0B0E00, 1'b1, -1);
        push_frame(258, 24'h0B0E00, 1'b1, 4);
        push_frame(258, 24'h0B0E00, 1'b1, 4);
        repeat (3) exp_sq.push_back(SMP2);
        ifa.continuous = 1'b1;
        wait_fq(1, 1500, "cont_timeout");
        wait_cs_low_a(50, "cont_third_timeout");
        ifa.continuous = 1'b0;
        wait_idle_a(800, "cont_end_timeout");

        // reset in the middle of a READ (no READ completed since this reset)
        rst_a = 1'b0;
        tick(3);
        push_frame(98, 24'h0A2D02, 1'b0, -1);
        rst_a = 1'b1;
        wait_idle_a(400, "abort_init_timeout");
        pulse_start_a();
        wait_cs_low_a(20, "abort_start_timeout");
        tick(100);
        chk("abort_pre_ncs", ifa.n_CS, 0);
        rst_a = 1'b0;
        tick(1);
        chk("abort_ncs", ifa.n_CS, 1);
        chk("abort_sclk", ifa.SCLK, 0);
        chk("abort_samples", ifa.samples, 0);
        chk("abort_valid", ifa.sample_valid, 0);
        tick(2);
        push_frame(98, 24'h0A2D02, 1'b0, -1);
        push_frame(258, 24'h0B0E00, 1'b1, 4);
        exp_sq.push_back(SMP2);
        ifa.continuous = 1'b1;
        rst_a = 1'b1;
        wait_fq(1, 600, "reinit_timeout");
        wait_cs_low_a(50, "reread_timeout");
        ifa.continuous = 1'b0;
        wait_idle_a(800, "reread_end_timeout");

        // DUT B: NUM_CH=1, SAMPLE_W=16, CLK_DIV=1
        ifb.continuous = 1'b1;
        rst_b = 1'b1;
        k = 0;
        while (ifb.n_CS && k < 50) begin tick(1); k++; end
        chk("b_init_start", k >= 50, 0);
        k = 0;
        while (!ifb.n_CS && k < 500) begin tick(1); k++; end
        chk("b_init_len", k, 49);
        chk("b_init_valid", ifb.sample_valid, 0);
        k = 0;
        while (ifb.n_CS && k < 50) begin tick(1); k++; end
        chk("b_gap", k, 4);
        k = 0;
        r1 = -1;
        r2 = -1;
        ps = 1'b0;
        while (!ifb.n_CS && k < 500) begin
            if (ifb.SCLK && !ps) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            ps = ifb.SCLK;
            tick(1);
            k++;
        end
        ifb.continuous = 1'b0;
        chk("b_read_len", k, 65);
        chk("b_valid", ifb.sample_valid, 1);
        chk("b_samples", ifb.samples, 16'hABCD);
        chk("b_sclk_period", r2 - r1, 2);
        tick(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/spi_burst_reader.md
# spi_burst_reader

Parametrised SPI master that sequences an accelerometer-style register device. After reset it performs one configuration write, then reads NUM_CH multi-byte samples per chip-select frame using a single auto-incrementing burst read. All samples of one frame are published atomically with a one-cycle valid strobe. SCLK is derived internally from the single block clock by a programmable divider, and bursts run either continuously or on request. It replaces the fixed 3-axis, one-register-per-frame interface between the accelerometer pins and the MIPS-side sample registers.

## Interface
- CLK_DIV, 4: clk_SPI cycles per SCLK half-period (≥1)
- NUM_CH, 3: channels per burst (1..8)
- SAMPLE_W, 12: bits per sample (9..16); low byte then high byte, high byte bits [SAMPLE_W-9:0] used
- BASE_ADDR, 8'h0E: address of channel 0 low byte
- INIT_ADDR, 8'h2D: configuration register address
- INIT_DATA, 8'h02: configuration value (measurement mode)
- GAP_CYC, 4: minimum clk_SPI cycles n_CS stays high between frames (≥1)
- clk_SPI  in  1  sole block clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- continuous  in  1  1: back-to-back bursts; 0: burst per request
- start  in  1  burst request pulse (used when continuous=0)
- MISO  in  1  serial data from device
- SCLK  out  1  SPI clock, mode 0 (idle low)
- MOSI  out  1  serial data to device
- n_CS  out  1  active-low chip select
- samples  out  NUM_CH*SAMPLE_W  channel k at [k*SAMPLE_W +: SAMPLE_W]
- sample_valid  out  1  one-cycle pulse when samples updates
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: GAP → SHIFT → CS_HOLD → GAP → (INIT done) IDLE/SHIFT.
- Frame types:
  - INIT: bytes 0x0A, INIT_ADDR, INIT_DATA (B=3). Issued exactly once after reset.
  - READ: bytes 0x0B, BASE_ADDR, then 2*NUM_CH data bytes (B=2+2*NUM_CH). MOSI=0 during data bytes.
- Bytes are sent MSB first. Data byte j (0-based after the address) is captured into staging:
  - even j → low byte of channel j/2
  - odd j → high byte of channel j/2
- After GAP: if INIT not yet done → INIT. Else if continuous=1 or pending=1 → READ. Else → IDLE.
- From IDLE: go to READ when continuous=1 or pending=1.
- pending flag:
  - set by start=1 in any cycle, including during INIT or an active READ
  - cleared in the cycle a READ frame begins
  - multiple starts before that cycle collapse into one READ
- At the end of a READ frame (n_CS rising cycle), staging is copied into samples and sample_valid=1 for that one cycle. The INIT frame does not pulse sample_valid.
- Reset values: n_CS=1, SCLK=0, MOSI=0, samples=0, sample_valid=0, busy=0, pending=0, INIT not done, staging=0.
- Reset asserted mid-frame:
  - n_CS=1 and SCLK=0 after that edge
  - partial staging is discarded; samples are not updated
  - INIT is redone after release

## Timing
- D=CLK_DIV. Cycle 0 is the first cycle with n_CS=0. MOSI holds bit 7 of byte 0 and SCLK=0.
- Bit i (i=0..8B-1):
  - SCLK=0 for cycles [2iD, 2iD+D)
  - SCLK=1 for cycles [2iD+D, 2iD+2D)
  - MOSI changes only at cycle 2iD
  - MISO is sampled at the clock edge that drives SCLK 0→1
- CS_HOLD: SCLK=0 and n_CS=0 for cycles [16BD, 16BD+D). n_CS=1 from cycle 16BD+D.
- Frame length with n_CS low = 16BD+D cycles. n_CS stays high for ≥GAP_CYC cycles (exactly GAP_CYC when the next frame is due).
- After reset release: E0 is the first edge with reset=1. n_CS first falls at edge E0+GAP_CYC, starting INIT.
- Request latency from IDLE: start at edge t → n_CS=0 after edge t+1.
- samples and sample_valid change on the same edge as n_CS rising.

## Test plan
- Defaults with CLK_DIV=2: after reset, INIT frame shifts 0x0A,0x2D,0x02 on MOSI. n_CS is low for 98 cycles, then high for exactly 4 cycles. No sample_valid pulse.
- continuous=1, MISO model returns 0x34,0x01,0xFF,0x0F,0x00,0x08:
  - READ frame has n_CS low for 258 cycles (B=8)
  - samples = {12'h800, 12'hFFF, 12'h134} (ch2..ch0)
  - sample_valid is high for 1 cycle
  - next n_CS fall comes 4 cycles later
- continuous=0: after INIT, no frame occurs. A start pulse gives n_CS=0 one cycle later. Three starts during that READ produce exactly one more READ.
- Start pulse during INIT → READ follows INIT after the GAP_CYC gap.
- NUM_CH=1, SAMPLE_W=16, CLK_DIV=1, MISO bytes 0xCD,0xAB:
  - samples=16'hABCD
  - frame n_CS low = 16*4+1 = 65 cycles
  - SCLK period is 2 cycles
- Reset asserted at cycle 100 of a READ:
  - next cycle n_CS=1, SCLK=0, samples unchanged from before the READ (0 if none completed)
  - after release, INIT is repeated before any READ
